// File: rtl/rcc_seq.sv
// rcc_seq: SDRAM-domain reset and clock-select sequencer.
// Holds the SDRAM domain in reset, then releases it and lets it settle.
// Clock source changes are glitch-safe: the clock is gated, the mux moves,
// and the clock is ungated only after settle periods on both sides.
// All outputs are registered and decoded from the next state.
module rcc_seq #(
    parameter int unsigned MUX_DELAY  = 2,
    parameter int unsigned SYNC_DELAY = 2,
    parameter int unsigned RST_HOLD   = 8
) (
    input  logic clk_i,
    input  logic hw_rst_i,
    input  logic sw_rst_req_i,
    input  logic sel_req_i,
    input  logic sel_i,
    output logic sel_ack_o,
    output logic clk_en_o,
    output logic clk_sel_o,
    output logic sdram_rst_o,
    output logic ready_o,
    output logic busy_o
);

    // Counter is wide enough for the largest timed state.
    localparam int unsigned MAX_MS = (MUX_DELAY > SYNC_DELAY) ? MUX_DELAY : SYNC_DELAY;
    localparam int unsigned MAX_P  = (MAX_MS > RST_HOLD) ? MAX_MS : RST_HOLD;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    // Reload values: a state lasts (load + 1) cycles, expiring when count is 0.
    localparam logic [CW-1:0] HOLD_LD = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_DELAY - 1);
    localparam logic [CW-1:0] MUX_LD  = CW'(MUX_DELAY - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_GATE,
        ST_SWITCH,
        ST_UNGATE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;     // reset requested during a switch
    logic            lat_q, lat_d;       // select value latched on acceptance
    logic            sel_q, sel_d;
    logic            en_q, en_d;
    logic            srst_q, srst_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : (cnt_q - CW'(1));
        pend_d  = pend_q;
        lat_d   = lat_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (cnt_zero) begin
                    state_d = ST_RELEASE;
                    cnt_d   = SYNC_LD;
                end
            end

            ST_RELEASE: begin
                if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Reset wins over a select request; a request is not taken
                // in the cycle the previous one is acknowledged.
                if (sw_rst_req_i || pend_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    pend_d  = 1'b0;
                end else if (sel_req_i && !ack_q) begin
                    if (sel_i != sel_q) begin
                        state_d = ST_GATE;
                        cnt_d   = MUX_LD;
                        lat_d   = sel_i;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end

            ST_GATE: begin
                pend_d = pend_q | sw_rst_req_i;
                if (cnt_zero) begin
                    state_d = ST_SWITCH;
                    cnt_d   = MUX_LD;
                    sel_d   = lat_q;
                end
            end

            ST_SWITCH: begin
                pend_d = pend_q | sw_rst_req_i;
                if (cnt_zero) begin
                    state_d = ST_UNGATE;
                    cnt_d   = SYNC_LD;
                end
            end

            ST_UNGATE: begin
                pend_d = pend_q | sw_rst_req_i;
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LD;
            end
        endcase

        // Clock is gated exactly while in GATE or SWITCH, so the mux only
        // moves (on SWITCH entry) with the gate already closed.
        en_d   = !((state_d == ST_GATE) || (state_d == ST_SWITCH));
        srst_d = (state_d == ST_HOLD);
        rdy_d  = (state_d == ST_RUN);
        busy_d = !rdy_d;
    end

    // State, counter and output registers with synchronous block reset.
    always_ff @(posedge clk_i) begin
        if (hw_rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LD;
            pend_q  <= 1'b0;
            lat_q   <= 1'b0;
            sel_q   <= 1'b0;
            en_q    <= 1'b1;
            srst_q  <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            lat_q   <= lat_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            srst_q  <= srst_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign sel_ack_o   = ack_q;
    assign clk_en_o    = en_q;
    assign clk_sel_o   = sel_q;
    assign sdram_rst_o = srst_q;
    assign ready_o     = rdy_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rcc_seq.sv
// tb_rcc_seq: directed scoreboard bench for rcc_seq (default parameters).
// Stimulus pushes expected output vectors (per cycle) and expected ack
// cycles into queues; a negedge monitor pops and compares them.
module tb_rcc_seq;

    logic clk = 1'b0;
    logic hw_rst_i = 1'b1;
    logic sw_rst_req_i = 1'b0;
    logic sel_req_i = 1'b0;
    logic sel_i = 1'b0;
    logic sel_ack_o, clk_en_o, clk_sel_o, sdram_rst_o, ready_o, busy_o;

    rcc_seq #(.MUX_DELAY(2), .SYNC_DELAY(2), .RST_HOLD(8)) dut (
        .clk_i       (clk),
        .hw_rst_i    (hw_rst_i),
        .sw_rst_req_i(sw_rst_req_i),
        .sel_req_i   (sel_req_i),
        .sel_i       (sel_i),
        .sel_ack_o   (sel_ack_o),
        .clk_en_o    (clk_en_o),
        .clk_sel_o   (clk_sel_o),
        .sdram_rst_o (sdram_rst_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Vector bit order: {clk_en, clk_sel, sdram_rst, ready}
    localparam logic [3:0] M_EN  = 4'b1000;
    localparam logic [3:0] M_SEL = 4'b0100;
    localparam logic [3:0] M_RST = 4'b0010;
    localparam logic [3:0] M_RDY = 4'b0001;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] mask;
        logic [3:0] val;
    } exp_t;

    exp_t exq[$];
    int   ackq[$];
    int   cyc = 0;
    logic hw_prev = 1'b1;
    logic sel_prev = 1'b0;
    logic done = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        hw_prev <= hw_rst_i;
    end

    function automatic void ex(int c, string n, logic [3:0] m, logic [3:0] v);
        exp_t e;
        e.cyc = c; e.name = n; e.mask = m; e.val = v;
        exq.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [3:0] act;
        act = {clk_en_o, clk_sel_o, sdram_rst_o, ready_o};
        if (!done) begin
            for (int i = exq.size() - 1; i >= 0; i--) begin
                if (exq[i].cyc == cyc) begin
                    checks++;
                    if ((act & exq[i].mask) !== (exq[i].val & exq[i].mask)) begin
                        errors++;
                        $display("FAIL %s @cyc %0d: got %b want %b (mask %b)",
                                 exq[i].name, cyc, act, exq[i].val, exq[i].mask);
                    end
                    exq.delete(i);
                end else if (exq[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expected cycle %0d passed unchecked", exq[i].name, exq[i].cyc);
                    exq.delete(i);
                end
            end
            if (sel_ack_o === 1'b1) begin
                checks++;
                if (ackq.size() != 0 && ackq[0] == cyc) begin
                    void'(ackq.pop_front());
                end else begin
                    errors++;
                    $display("FAIL sel_ack: got ack at cyc %0d, want %0d",
                             cyc, (ackq.size() != 0) ? ackq[0] : -1);
                end
            end
            if (ackq.size() != 0 && ackq[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL sel_ack: got none, want ack at cyc %0d", ackq[0]);
                void'(ackq.pop_front());
            end
            checks++;
            if (busy_o !== ~ready_o) begin
                errors++;
                $display("FAIL busy_inv @cyc %0d: got busy=%b, want %b", cyc, busy_o, ~ready_o);
            end
            if (clk_sel_o !== sel_prev && !hw_prev && !$isunknown(clk_sel_o)) begin
                checks++;
                if (clk_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch @cyc %0d: got clk_en=%b during sel change, want 0", cyc, clk_en_o);
                end
            end
            sel_prev <= clk_sel_o;
        end else begin
            checks++;
            if (exq.size() != 0 || ackq.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d vectors/%0d acks pending, want 0/0", exq.size(), ackq.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Stimulus
    initial begin
        int t, c0;
        step(1);

        // Block reset and power-up sequence
        t = cyc;
        ex(t + 1, "rst_state", M_ALL, 4'b1010);
        step(1);
        hw_rst_i = 1'b0;
        c0 = cyc;
        ex(c0 + 7,  "hold_last",  M_RST | M_RDY, 4'b0010);
        ex(c0 + 8,  "release0",   M_RST | M_RDY, 4'b0000);
        ex(c0 + 9,  "release1",   M_RST | M_RDY, 4'b0000);
        ex(c0 + 10, "first_run",  M_ALL,         4'b1001);
        step(12);

        // Clean switch 0 -> 1
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b1;
        ex(t + 1, "gate0",   M_EN | M_SEL, 4'b0000);
        ex(t + 2, "gate1",   M_EN | M_SEL, 4'b0000);
        ex(t + 3, "switch0", M_EN | M_SEL, 4'b0100);
        ex(t + 4, "switch1", M_EN | M_SEL, 4'b0100);
        ex(t + 5, "ungate0", M_ALL,        4'b1100);
        ex(t + 6, "ungate1", M_ALL,        4'b1100);
        ex(t + 7, "sw_done", M_ALL,        4'b1101);
        ackq.push_back(t + 7);
        step(7);
        sel_req_i = 1'b0;
        step(3);

        // Same select: immediate ack, request held through ack cycle
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b1;
        ackq.push_back(t + 1);
        ex(t + 1, "same_sel0", M_ALL, 4'b1101);
        ex(t + 2, "same_sel1", M_ALL, 4'b1101);
        step(2);
        sel_req_i = 1'b0;
        step(3);

        // Clean switch 1 -> 0
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b0;
        ex(t + 2, "gate_b",   M_EN | M_SEL, 4'b0100);
        ex(t + 3, "switch_b", M_EN | M_SEL, 4'b0000);
        ex(t + 7, "done_b",   M_ALL,        4'b1001);
        ackq.push_back(t + 7);
        step(7);
        sel_req_i = 1'b0;
        step(3);

        // Switch 0 -> 1 with software reset during GATE
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b1;
        ex(t + 3,  "pend_switch", M_EN | M_SEL, 4'b0100);
        ex(t + 7,  "pend_ack",    M_ALL,        4'b1101);
        ex(t + 8,  "pend_hold0",  M_ALL,        4'b1110);
        ex(t + 15, "pend_hold7",  M_ALL,        4'b1110);
        ex(t + 16, "pend_rel",    M_ALL,        4'b1100);
        ex(t + 18, "pend_run",    M_ALL,        4'b1101);
        ackq.push_back(t + 7);
        step(2);
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        step(4);
        sel_req_i = 1'b0;
        step(13);

        // Reset and select in the same RUN cycle: reset first, then switch 1 -> 0
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b0; sw_rst_req_i = 1'b1;
        ex(t + 1,  "both_hold",   M_ALL,        4'b1110);
        ex(t + 8,  "both_hold7",  M_RST,        4'b0010);
        ex(t + 9,  "both_rel",    M_ALL,        4'b1100);
        ex(t + 11, "both_run",    M_ALL,        4'b1101);
        ex(t + 12, "both_gate",   M_EN | M_SEL, 4'b0100);
        ex(t + 14, "both_switch", M_EN | M_SEL, 4'b0000);
        ex(t + 18, "both_done",   M_ALL,        4'b1001);
        ackq.push_back(t + 18);
        step(1);
        sw_rst_req_i = 1'b0;
        step(17);
        sel_req_i = 1'b0;
        step(3);

        // Software reset during RELEASE restarts the full hold
        t = cyc;
        sw_rst_req_i = 1'b1;
        ex(t + 9,  "rst_rel",     M_RST | M_RDY, 4'b0000);
        ex(t + 10, "restart0",    M_RST | M_RDY, 4'b0010);
        ex(t + 17, "restart7",    M_RST | M_RDY, 4'b0010);
        ex(t + 18, "restart_rel", M_RST | M_RDY, 4'b0000);
        ex(t + 19, "restart_rel1", M_RST | M_RDY, 4'b0000);
        ex(t + 20, "restart_run", M_ALL,         4'b1001);
        step(1);
        sw_rst_req_i = 1'b0;
        step(8);
        sw_rst_req_i = 1'b1;
        step(1);
        sw_rst_req_i = 1'b0;
        step(12);

        // Block reset in the middle of SWITCH: no ack, back to defaults
        t = cyc;
        sel_req_i = 1'b1; sel_i = 1'b1;
        ex(t + 3,  "hw_switch",   M_EN | M_SEL, 4'b0100);
        ex(t + 4,  "hw_mid",      M_ALL,        4'b1010);
        ex(t + 11, "hw_hold7",    M_RST,        4'b0010);
        ex(t + 14, "hw_run",      M_ALL,        4'b1001);
        step(3);
        hw_rst_i = 1'b1;
        step(1);
        hw_rst_i = 1'b0;
        sel_req_i = 1'b0;
        step(12);

        done = 1'b1;
        step(3);
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want summary before timeout");
        $fatal(1, "timeout");
    end

endmodule
